fp32_accum_seq: RTL

- Sequencer directly upstream of the team's handshaked FP32 adder. Accumulates a stream of IEEE-754 single-precision values into a running sum.
- Accepts one element at a time on an input stb/ack channel. Sends (running sum, element) to the adder's A and B channels, then takes the adder result back as the new sum.
- On the element tagged last, emits the total and the element count, then clears for the next vector.
- Used by the EPU to reduce partial products from the PE array.

---
 rtl/fp32_accum_seq.sv | 109 ++++++++++
 1 files changed

// File: rtl/fp32_accum_seq.sv
// Sequencer that folds an FP32 element stream into a running sum through an
// external handshaked adder; emits sum, element count and NaN flag per vector.
module fp32_accum_seq #(
  parameter int unsigned CNT_W    = 16,
  parameter logic [31:0] INIT_VAL = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  input  logic             in_stb,
  output logic             in_ack,
  output logic [31:0]      add_a,
  output logic             add_a_stb,
  input  logic             add_a_ack,
  output logic [31:0]      add_b,
  output logic             add_b_stb,
  input  logic             add_b_ack,
  input  logic [31:0]      add_z,
  input  logic             add_z_stb,
  output logic             add_z_ack,
  output logic [31:0]      out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_nan,
  output logic             out_stb,
  input  logic             out_ack
);

  typedef enum logic [2:0] {
    IDLE,
    SEND_A,
    SEND_B,
    WAIT_Z,
    EMIT
  } state_t;

  state_t           state;
  logic [31:0]      acc;
  logic [31:0]      elem;
  logic [CNT_W-1:0] cnt;
  logic             nan_seen;
  logic             last_r;
  logic             z_is_nan;

  assign z_is_nan = (add_z[30:23] == 8'hFF) && (add_z[22:0] != '0);

  // IDLE decodes to 1 the moment reset releases, but must read 0 while reset is held.
  assign in_ack    = (state == IDLE) && !rst;
  assign add_a_stb = (state == SEND_A);
  assign add_b_stb = (state == SEND_B);
  assign add_z_ack = (state == WAIT_Z);
  assign out_stb   = (state == EMIT);

  assign add_a     = acc;
  assign add_b     = elem;
  assign out_sum   = acc;
  assign out_count = cnt;
  assign out_nan   = nan_seen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= INIT_VAL;
      cnt      <= '0;
      nan_seen <= 1'b0;
      elem     <= '0;
      last_r   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (clr) begin
            acc      <= INIT_VAL;
            cnt      <= '0;
            nan_seen <= 1'b0;
          end else if (in_stb) begin
            elem   <= in_data;
            last_r <= in_last;
            state  <= SEND_A;
          end
        end
        SEND_A: begin
          if (add_a_ack) state <= SEND_B;
        end
        SEND_B: begin
          if (add_b_ack) state <= WAIT_Z;
        end
        WAIT_Z: begin
          if (add_z_stb) begin
            acc      <= add_z;
            cnt      <= (cnt == '1) ? cnt : cnt + 1'b1;
            nan_seen <= nan_seen | z_is_nan;
            state    <= last_r ? EMIT : IDLE;
          end
        end
        EMIT: begin
          if (out_ack) begin
            acc      <= INIT_VAL;
            cnt      <= '0;
            nan_seen <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
